// File: rtl/ifu_redirect_ctrl_if.sv
// Fetch-group handshake, per-slot predecode/BPD inputs and redirect outputs
// of the post-predecode redirect controller.
interface ifu_redirect_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic        in_v1;
  logic        pd0_isJ;
  logic        pd0_isBr;
  logic        pd0_jr;
  logic [31:0] pd0_target;
  logic        pd1_isJ;
  logic        pd1_isBr;
  logic        pd1_jr;
  logic [31:0] pd1_target;
  logic        bpd0_taken;
  logic        bpd1_taken;
  logic [31:0] bpd_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [1:0]  out_mask;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        backend_flush;
  logic [1:0]  dbg_state;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds valid and payload stable until that edge.
  modport master (
    output in_valid, in_pc, in_v1,
           pd0_isJ, pd0_isBr, pd0_jr, pd0_target,
           pd1_isJ, pd1_isBr, pd1_jr, pd1_target,
           bpd0_taken, bpd1_taken, bpd_target,
           out_ready, backend_flush,
    input  in_ready, out_valid, out_pc, out_mask,
           redirect_valid, redirect_target, dbg_state
  );

  modport slave (
    input  in_valid, in_pc, in_v1,
           pd0_isJ, pd0_isBr, pd0_jr, pd0_target,
           pd1_isJ, pd1_isBr, pd1_jr, pd1_target,
           bpd0_taken, bpd1_taken, bpd_target,
           out_ready, backend_flush,
    output in_ready, out_valid, out_pc, out_mask,
           redirect_valid, redirect_target, dbg_state
  );
endinterface

// File: rtl/ifu_redirect_ctrl.sv
// Post-predecode fetch redirect controller: masks slots past the MIPS delay
// slot and pulses a redirect once the delay slot has gone downstream.
module ifu_redirect_ctrl (
  input logic             clk,
  input logic             rst,
  ifu_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {RUN = 2'd0, WAIT_DS = 2'd1, REDIR = 2'd2} state_t;

  state_t      state, state_n;
  logic [31:0] tgt, tgt_n;
  logic        out_valid_q;
  logic [31:0] out_pc_q;
  logic [1:0]  out_mask_q, mask_n;
  logic        pd_take0, pd_take1, ctl0, ctl1;
  logic [31:0] target0, target1;
  logic        in_ready, accept;

  // J/JAL and predicted-taken branches use the predecoded target; only a
  // predicted-taken JR/JALR falls back to the BPD target.
  assign pd_take0 = (bus.pd0_isJ && !bus.pd0_jr) || (bus.pd0_isBr && bus.bpd0_taken);
  assign pd_take1 = (bus.pd1_isJ && !bus.pd1_jr) || (bus.pd1_isBr && bus.bpd1_taken);
  assign ctl0     = pd_take0 || (bus.pd0_jr && bus.bpd0_taken);
  assign ctl1     = bus.in_v1 && (pd_take1 || (bus.pd1_jr && bus.bpd1_taken));
  assign target0  = pd_take0 ? bus.pd0_target : bus.bpd_target;
  assign target1  = pd_take1 ? bus.pd1_target : bus.bpd_target;

  // REDIR swallows the wrong-path group regardless of downstream state.
  assign in_ready = !bus.backend_flush &&
                    ((state == REDIR) || !out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready && (state != REDIR);

  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    mask_n  = {bus.in_v1, 1'b1};
    if (bus.backend_flush) begin
      state_n = RUN;
    end else begin
      case (state)
        RUN: begin
          if (accept) begin
            if (ctl0) begin
              tgt_n = target0;
              if (bus.in_v1) begin
                mask_n  = 2'b11;
                state_n = REDIR;
              end else begin
                mask_n  = 2'b01;
                state_n = WAIT_DS;
              end
            end else if (ctl1) begin
              tgt_n   = target1;
              mask_n  = 2'b11;
              state_n = WAIT_DS;
            end
          end
        end
        WAIT_DS: begin
          mask_n = 2'b01;
          if (accept) state_n = REDIR;
        end
        REDIR:   state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      tgt         <= 32'h0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'h0;
      out_mask_q  <= 2'b00;
    end else begin
      state <= state_n;
      tgt   <= tgt_n;
      if (bus.backend_flush) begin
        out_valid_q <= 1'b0;
      end else if (accept) begin
        out_valid_q <= 1'b1;
        out_pc_q    <= bus.in_pc;
        out_mask_q  <= mask_n;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready        = in_ready;
  assign bus.out_valid       = out_valid_q;
  assign bus.out_pc          = out_pc_q;
  assign bus.out_mask        = out_mask_q;
  assign bus.redirect_valid  = (state == REDIR) && !bus.backend_flush;
  assign bus.redirect_target = tgt;
  assign bus.dbg_state       = state;
endmodule

// File: doc/ifu_redirect_ctrl.md
# ifu_redirect_ctrl

Post-predecode fetch redirect controller for the 2-wide IFU. It consumes one fetch group per handshake, along with per-slot predecode results from two predecoder instances and per-slot BPD direction bits. It masks off instructions past the MIPS delay slot and issues a single-cycle redirect to the PC generator once the delay slot has been delivered downstream. It sits between the IF/predecode stage and the instruction buffer.

## Interface
Parameters:
- none (fetch width fixed at 2; slot1 PC is always pc+4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch group valid
- in_ready  out  1  group accepted when in_valid && in_ready
- in_pc  in  32  slot0 PC
- in_v1  in  1  slot1 valid (slot0 is always valid when in_valid)
- pd0_isJ, pd0_isBr, pd0_jr  in  1 each  slot0 predecode
- pd0_target  in  32  slot0 predecoded target (J/JAL/branch)
- pd1_isJ, pd1_isBr, pd1_jr, pd1_target  in  1/1/1/32  slot1 predecode
- bpd0_taken, bpd1_taken  in  1 each  BPD taken prediction per slot
- bpd_target  in  32  BPD target (used only for JR/JALR)
- out_valid  out  1  registered group to instruction buffer
- out_ready  in  1  instruction buffer can accept
- out_pc  out  32  group PC
- out_mask  out  2  bit i = slot i delivered
- redirect_valid  out  1  one-cycle redirect pulse to PC generator
- redirect_target  out  32  redirect PC
- backend_flush  in  1  commit-side flush; highest priority

## Operation
- States: RUN, WAIT_DS, REDIR. Pending target register `tgt`.
- Slot i is a control slot (ctl_i) when:
  - isJ && !jr (J/JAL) → taken, target pd_target; BPD is ignored.
  - isBr && bpd_taken → taken, target pd_target. This overrides any BPD target.
  - jr && bpd_taken → taken, target bpd_target.
  - jr && !bpd_taken, or a branch predicted not-taken → not a control slot; fall through. The backend resolves it.
- RUN, on accept:
  - First ctl slot is slot0 with in_v1=1: out_mask=11, tgt←target, go to REDIR.
  - ctl at slot0 with in_v1=0: out_mask=01, tgt←target, go to WAIT_DS.
  - ctl at slot1 (slot0 not ctl): out_mask=11, tgt←target, go to WAIT_DS.
  - No ctl slot: out_mask={in_v1,1}, stay in RUN.
- WAIT_DS, on accept: out_mask=01 (delay slot only). Predecode of the delay slot is ignored; control in a delay slot is UNPREDICTABLE and never redirects. Go to REDIR.
- REDIR (exactly one cycle):
  - redirect_valid=1, redirect_target=tgt.
  - in_ready=1; any offered group is consumed and discarded (wrong path). It does not load the output register.
  - Next state is RUN.
- Output register:
  - in_ready = (state != REDIR) ? (!out_valid || out_ready) : 1.
  - On accept (not REDIR), out_valid←1 and out_pc/out_mask load.
  - Otherwise, if out_ready, out_valid←0.
- backend_flush:
  - out_valid←0, state←RUN, no redirect issued.
  - in_ready=0 in the flush cycle; nothing is accepted.
  - Overrides REDIR and WAIT_DS (pending redirect dropped).
- Reset: state RUN; out_valid 0, out_pc 0, out_mask 00, redirect_valid 0, redirect_target 0, tgt 0.

## Timing
- Group accepted at edge T → visible on out_* from T+1 (1-cycle latency).
- ctl in slot0 with slot1 valid: group accepted at T → redirect_valid=1 during T+1 only; RUN from T+2.
- ctl in slot1: accepted at T → WAIT_DS. Delay-slot group accepted at T+k (k≥1, any stall length) → redirect_valid during T+k+1.
- redirect_valid is never high for two consecutive cycles and is never high in a flush cycle.
- Backpressure (out_valid && !out_ready) holds out_* stable and deasserts in_ready; WAIT_DS persists indefinitely.
- rst mid-WAIT_DS or mid-REDIR: next cycle is the reset state; no redirect.

## Test plan
- J at slot0 of group pc=0xBFC00000, in_v1=1, pd0_target=0xBFC01000 → out_mask=11 at T+1, redirect_valid=1 with target 0xBFC01000 at T+1, next group at T+1 discarded.
- BEQ at slot1 of pc=0x80000000 (bpd1_taken=1, target 0x80000040); next group pc=0x80000008 with out_ready low for 3 cycles → mask 11, then WAIT_DS held, delay group mask=01, redirect 0x80000040 one cycle after its accept.
- JR slot0 with bpd0_taken=0 → no redirect, mask=11. JR slot0 with bpd0_taken=1, bpd_target=0x80001234 → redirect to 0x80001234.
- BNE slot0 with bpd0_taken=0 and J in slot1 → slot1 is ctl, WAIT_DS entered.
- J slot0, in_v1=0 → mask 01, WAIT_DS; J present in the delay-slot group → ignored, single redirect to the first target.
- backend_flush asserted in WAIT_DS and in the REDIR cycle → out_valid=0 next cycle, redirect_valid=0, state RUN; rst during backpressure → all outputs zero next cycle.
